pipe_stage_buf: RTL and testbench
=================================

// Module: pipe_stage_buf
// PURPOSE
//  Generic, parametrised pipeline stage register replacing hand-written per-stage latches
//  (IF/ID, ID/EX, EX/MEM, MEM/WB). Carries an opaque payload plus a control field that is
//  zeroed for bubbles, with valid/ready flow control, synchronous flush and bubble insertion.
//  Sits between two datapath stages; one instance per boundary.
// PARAMETERS
//  DATA_W  128  payload width (instr, npc, operands); held, never forced to 0 on bubble
//  CTRL_W  16   control width (wen, ren, halt, sels); forced to 0 whenever valid_o=0
// PORTS
//  CLK      in   1       clock, all state on rising edge
//  nRST     in   1       asynchronous reset, active low
//  flush    in   1       discard all held/incoming beats this cycle
//  bubble_i in   1       insert bubble: stall upstream, send invalid downstream
//  valid_i  in   1       upstream beat valid
//  ready_o  out  1       stage can accept a beat
//  data_i   in   DATA_W  upstream payload
//  ctrl_i   in   CTRL_W  upstream control
//  valid_o  out  1       downstream beat valid
//  ready_i  in   1       downstream accepts
//  data_o   out  DATA_W  payload to downstream
//  ctrl_o   out  CTRL_W  control to downstream (0 when valid_o=0)
//  occ_o    out  2       beats held (0..1; 0..2 with skid)
// BEHAVIOUR
//  - Clock CLK, reset nRST: one clock; reset asynchronous, active low.
//  - Reset: valid_o=0, data_o=0, ctrl_o=0, occ_o=0, skid empty, ready_o=1.
//  - Accept = valid_i & ready_o; emit = valid_o & ready_i. Latency 1 cycle: i->o.
//  - ctrl_o = valid_o ? ctrl_q : 0 (combinational gate); data_o holds last value.
//  - Priority per cycle: flush > bubble_i > normal.
//  - flush: next valid_o=0, skid cleared, occ_o=0; beat accepted same cycle is dropped.
//    ready_o not gated by flush.
//  - bubble_i (no flush): ready_o=0. If emit or !valid_o then valid_o<=0, else hold.
//    Skid (if present) still drains to output.
//  - Normal, no skid: ready_o = !valid_o | ready_i (combinational).
//    Output loads on accept, clears valid on emit without accept.
//  - valid_o held with ready_i=0: data_o/ctrl_o stable until emit (no overwrite).
//  - occ_o = valid_o + skid_valid.
// CONFIGURATION
//  PIPE_STAGE_SKID_EN defined: adds one-entry skid buffer.
//   - ready_o = !skid_valid & !bubble_i: registered-path only, no ready_i->ready_o comb path.
//   - Accept while output stalled -> beat enters skid.
//   - On emit, skid moves to output the next cycle (or the new input if skid empty).
//   - Order strictly preserved. Full throughput at ready_i=1.
//  Undefined: no skid storage; ready_o combinational as above; occ_o max 1.
// TESTING
//  1. Reset mid-stream: valid_o=1, data_o=0xAA, drop nRST async -> valid_o=0, data_o=0,
//     ctrl_o=0 before next edge.
//  2. Streaming, ready_i=1: beats 1..8 on consecutive cycles -> data_o 1..8, one cycle later,
//     no gaps.
//  3. Backpressure: ready_i=0 for 3 cycles with beat 0x5 held.
//     -> data_o=0x5 stable; no-skid ready_o=0.
//     -> skid: beat 0x6 absorbed, ready_o=0, occ_o=2; release -> 0x5 then 0x6.
//  4. Flush with beat accepted same cycle (ctrl_i=0xFFFF) -> next cycle valid_o=0,
//     ctrl_o=0, occ_o=0; beat never emitted.
//  5. bubble_i=1 for 1 cycle with valid_i=1, data_i=0x7 -> ready_o=0; valid_o=0, ctrl_o=0
//     next cycle; 0x7 accepted the cycle after, emitted once.
//  6. flush & bubble_i together, skid holding a beat -> flush wins: valid_o=0, skid empty.

Source files
------------

// File: rtl/pipe_stage_buf.sv
// Pipeline boundary register: payload + control with valid/ready, sync flush, bubble insert.
// Latency: 1 cycle input->output. Optional one-entry skid buffer (macro PIPE_STAGE_SKID_EN).
// Backpressure: without skid ready_o = !valid_o | ready_i; with skid ready_o is registered-only.
//
// Ports:
//   CLK, nRST            clock (rising edge), asynchronous active-low reset
//   flush                drop held and same-cycle beats (highest priority)
//   bubble_i             stall upstream (ready_o=0) and let the output drain to invalid
//   valid_i/ready_o      upstream handshake, data_i/ctrl_i upstream beat
//   valid_o/ready_i      downstream handshake, data_o/ctrl_o downstream beat
//   occ_o                beats currently held (output register + skid entry)
//
// Build option: define PIPE_STAGE_SKID_EN to add the skid entry, which breaks the
// ready_i->ready_o combinational path at the cost of one extra beat of storage.

module pipe_stage_buf #(
    parameter int DATA_W = 128,
    parameter int CTRL_W = 16
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              flush,
    input  logic              bubble_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [DATA_W-1:0] data_i,
    input  logic [CTRL_W-1:0] ctrl_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [DATA_W-1:0] data_o,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic [1:0]        occ_o
);

    logic              r_valid;
    logic [DATA_W-1:0] r_data;
    logic [CTRL_W-1:0] r_ctrl;

    logic w_accept;
    logic w_out_free;
    logic w_skid_cnt;

    // Output register may take a new beat this cycle: empty, or its beat leaves now.
    assign w_out_free = !r_valid | ready_i;
    assign w_accept   = valid_i & ready_o;

`ifdef PIPE_STAGE_SKID_EN
    logic              r_skid_vld;
    logic [DATA_W-1:0] r_skid_data;
    logic [CTRL_W-1:0] r_skid_ctrl;

    // Depends only on state and bubble_i, never on ready_i.
    assign ready_o    = !r_skid_vld & !bubble_i;
    assign w_skid_cnt = r_skid_vld;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_valid     <= 1'b0;
            r_data      <= '0;
            r_ctrl      <= '0;
            r_skid_vld  <= 1'b0;
            r_skid_data <= '0;
            r_skid_ctrl <= '0;
        end else if (flush) begin
            r_valid    <= 1'b0;
            r_skid_vld <= 1'b0;
        end else if (w_out_free) begin
            // Skid beat is older than anything on the input, so it goes first.
            // While the skid is full ready_o is 0, so no input beat is lost here.
            if (r_skid_vld) begin
                r_valid    <= 1'b1;
                r_data     <= r_skid_data;
                r_ctrl     <= r_skid_ctrl;
                r_skid_vld <= 1'b0;
            end else if (w_accept) begin
                r_valid <= 1'b1;
                r_data  <= data_i;
                r_ctrl  <= ctrl_i;
            end else begin
                r_valid <= 1'b0;
            end
        end else if (w_accept) begin
            // Output stalled: park the accepted beat in the skid entry.
            r_skid_vld  <= 1'b1;
            r_skid_data <= data_i;
            r_skid_ctrl <= ctrl_i;
        end
    end
`else
    assign ready_o    = !bubble_i & w_out_free;
    assign w_skid_cnt = 1'b0;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_ctrl  <= '0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (w_out_free) begin
            // A bubble forces w_accept low, so the output simply drains to invalid.
            if (w_accept) begin
                r_valid <= 1'b1;
                r_data  <= data_i;
                r_ctrl  <= ctrl_i;
            end else begin
                r_valid <= 1'b0;
            end
        end
    end
`endif

    assign valid_o = r_valid;
    assign data_o  = r_data;
    // Control is masked so a bubble can never carry stale write/halt enables downstream.
    assign ctrl_o  = r_valid ? r_ctrl : '0;
    assign occ_o   = {1'b0, r_valid} + {1'b0, w_skid_cnt};

endmodule

// File: tb/tb_pipe_stage_buf.sv
module tb_pipe_stage_buf;

    localparam int DATA_W = 128;
    localparam int CTRL_W = 16;

    logic              CLK;
    logic              nRST;
    logic              flush;
    logic              bubble_i;
    logic              valid_i;
    logic              ready_o;
    logic [DATA_W-1:0] data_i;
    logic [CTRL_W-1:0] ctrl_i;
    logic              valid_o;
    logic              ready_i;
    logic [DATA_W-1:0] data_o;
    logic [CTRL_W-1:0] ctrl_o;
    logic [1:0]        occ_o;

    int n_chk;
    int n_err;

    pipe_stage_buf #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) dut (
        .CLK      (CLK),
        .nRST     (nRST),
        .flush    (flush),
        .bubble_i (bubble_i),
        .valid_i  (valid_i),
        .ready_o  (ready_o),
        .data_i   (data_i),
        .ctrl_i   (ctrl_i),
        .valid_o  (valid_o),
        .ready_i  (ready_i),
        .data_o   (data_o),
        .ctrl_o   (ctrl_o),
        .occ_o    (occ_o)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        n_chk    = 0;
        n_err    = 0;
        nRST     = 1'b0;
        flush    = 1'b0;
        bubble_i = 1'b0;
        valid_i  = 1'b0;
        ready_i  = 1'b0;
        data_i   = '0;
        ctrl_i   = '0;

        // Reset state
        #12;
        chk("rst_valid", 128'(valid_o), 128'd0);
        chk("rst_data",  data_o,        128'd0);
        chk("rst_ctrl",  128'(ctrl_o),  128'd0);
        chk("rst_occ",   128'(occ_o),   128'd0);
        chk("rst_ready", 128'(ready_o), 128'd1);
        nRST = 1'b1;

        // 1. Asynchronous reset mid-stream
        valid_i = 1'b1; data_i = 128'hAA; ctrl_i = 16'h1234; ready_i = 1'b0;
        tick();
        valid_i = 1'b0;
        chk("t1_valid_pre", 128'(valid_o), 128'd1);
        chk("t1_data_pre",  data_o,        128'hAA);
        chk("t1_ctrl_pre",  128'(ctrl_o),  128'h1234);
        #2 nRST = 1'b0;
        #1;
        chk("t1_valid_async", 128'(valid_o), 128'd0);
        chk("t1_data_async",  data_o,        128'd0);
        chk("t1_ctrl_async",  128'(ctrl_o),  128'd0);
        chk("t1_occ_async",   128'(occ_o),   128'd0);
        #1 nRST = 1'b1;

        // 2. Streaming at full throughput
        ready_i = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            valid_i = 1'b1; data_i = 128'(i); ctrl_i = 16'(i);
            #1;
            chk("t2_ready", 128'(ready_o), 128'd1);
            tick();
            chk("t2_valid", 128'(valid_o), 128'd1);
            chk("t2_data",  data_o,        128'(i));
        end
        valid_i = 1'b0;
        tick();
        chk("t2_drain_valid", 128'(valid_o), 128'd0);

        // 3. Backpressure
        ready_i = 1'b0; valid_i = 1'b1; data_i = 128'h5; ctrl_i = 16'h5;
        tick();
        chk("t3_valid_e1", 128'(valid_o), 128'd1);
        chk("t3_data_e1",  data_o,        128'h5);
        data_i = 128'h6; ctrl_i = 16'h6;
        #1;
`ifdef PIPE_STAGE_SKID_EN
        chk("t3_ready_skid_in", 128'(ready_o), 128'd1);
`else
        chk("t3_ready_stall",   128'(ready_o), 128'd0);
`endif
        tick();
        chk("t3_data_e2",  data_o,        128'h5);
        chk("t3_valid_e2", 128'(valid_o), 128'd1);
        chk("t3_ready_e2", 128'(ready_o), 128'd0);
`ifdef PIPE_STAGE_SKID_EN
        chk("t3_occ_e2", 128'(occ_o), 128'd2);
`else
        chk("t3_occ_e2", 128'(occ_o), 128'd1);
`endif
        tick();
        chk("t3_data_e3", data_o,       128'h5);
        chk("t3_ctrl_e3", 128'(ctrl_o), 128'h5);
        tick();
        chk("t3_data_e4", data_o, 128'h5);
        ready_i = 1'b1;
        #1;
`ifdef PIPE_STAGE_SKID_EN
        chk("t3_ready_release", 128'(ready_o), 128'd0);
`else
        chk("t3_ready_release", 128'(ready_o), 128'd1);
`endif
        tick();
        valid_i = 1'b0;
        chk("t3_data_second",  data_o,        128'h6);
        chk("t3_valid_second", 128'(valid_o), 128'd1);
        chk("t3_ctrl_second",  128'(ctrl_o),  128'h6);
        chk("t3_occ_second",   128'(occ_o),   128'd1);
        tick();
        chk("t3_valid_done", 128'(valid_o), 128'd0);
        chk("t3_ctrl_done",  128'(ctrl_o),  128'd0);
        chk("t3_occ_done",   128'(occ_o),   128'd0);

        // 4. Flush with a beat accepted in the same cycle
        valid_i = 1'b1; data_i = 128'h44; ctrl_i = 16'hFFFF; flush = 1'b1;
        #1;
        chk("t4_ready_flush", 128'(ready_o), 128'd1);
        tick();
        flush = 1'b0; valid_i = 1'b0;
        chk("t4_valid", 128'(valid_o), 128'd0);
        chk("t4_ctrl",  128'(ctrl_o),  128'd0);
        chk("t4_occ",   128'(occ_o),   128'd0);
        tick();
        chk("t4_never_emitted", 128'(valid_o), 128'd0);

        // 5. Bubble insertion
        bubble_i = 1'b1; valid_i = 1'b1; data_i = 128'h7; ctrl_i = 16'h7;
        #1;
        chk("t5_ready_bubble", 128'(ready_o), 128'd0);
        tick();
        bubble_i = 1'b0;
        chk("t5_valid_bubble", 128'(valid_o), 128'd0);
        chk("t5_ctrl_bubble",  128'(ctrl_o),  128'd0);
        #1;
        chk("t5_ready_after", 128'(ready_o), 128'd1);
        tick();
        valid_i = 1'b0;
        chk("t5_valid_7", 128'(valid_o), 128'd1);
        chk("t5_data_7",  data_o,        128'h7);
        chk("t5_ctrl_7",  128'(ctrl_o),  128'h7);
        tick();
        chk("t5_once", 128'(valid_o), 128'd0);
        // Bubble while output stalled holds the beat; with ready_i it drains to invalid.
        ready_i = 1'b0; valid_i = 1'b1; data_i = 128'h8; ctrl_i = 16'h8;
        tick();
        valid_i = 1'b0; bubble_i = 1'b1;
        tick();
        chk("t5_hold_valid", 128'(valid_o), 128'd1);
        chk("t5_hold_data",  data_o,        128'h8);
        chk("t5_hold_ready", 128'(ready_o), 128'd0);
        ready_i = 1'b1;
        tick();
        bubble_i = 1'b0;
        chk("t5_drain_valid", 128'(valid_o), 128'd0);
        chk("t5_drain_ctrl",  128'(ctrl_o),  128'd0);

        // 6. Flush and bubble together with storage occupied
        ready_i = 1'b0; valid_i = 1'b1; data_i = 128'h9; ctrl_i = 16'h9;
        tick();
        data_i = 128'hA; ctrl_i = 16'hA;
        tick();
`ifdef PIPE_STAGE_SKID_EN
        chk("t6_occ_full", 128'(occ_o), 128'd2);
`else
        chk("t6_occ_full", 128'(occ_o), 128'd1);
`endif
        flush = 1'b1; bubble_i = 1'b1;
        tick();
        flush = 1'b0; bubble_i = 1'b0; valid_i = 1'b0;
        chk("t6_valid", 128'(valid_o), 128'd0);
        chk("t6_occ",   128'(occ_o),   128'd0);
        chk("t6_ctrl",  128'(ctrl_o),  128'd0);
        ready_i = 1'b1;
        tick();
        chk("t6_no_drain", 128'(valid_o), 128'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
